armleo_stream_serializer: RTL and testbench



---
 rtl/armleo_stream_pkg.sv | 9 +
 rtl/armleo_stream_serializer.sv | 86 ++++++++
 tb/tb_armleo_stream_serializer.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/armleo_stream_pkg.sv
// Helpers shared by the armleo stream width converters (serializer and deserializer).
package armleo_stream_pkg;

    // Counter width that stays at least one bit, even for a ratio of 1 or 2.
    function automatic int clog2_min1(input int x);
        return (x <= 2) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/armleo_stream_serializer.sv
// Valid/ready width downsizer: one RATIO*DW-bit word in, RATIO DW-bit beats out, LSB slice first.
// in_ready depends combinationally on out_ready so a new word can load on the final beat.
module armleo_stream_serializer
    import armleo_stream_pkg::*;
#(
    parameter int DW    = 8,
    parameter int RATIO = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [DW*RATIO-1:0] in_data,
    output logic                in_ready,
    output logic                out_valid,
    output logic [DW-1:0]       out_data,
    output logic                out_last,
    input  logic                out_ready
);

    localparam int IDX_W = clog2_min1(RATIO);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

    generate
        if (RATIO < 2) begin : g_bad_ratio
            $error("armleo_stream_serializer: RATIO must be >= 2");
        end
        if (DW < 1) begin : g_bad_dw
            $error("armleo_stream_serializer: DW must be >= 1");
        end
    endgenerate

    logic [DW*RATIO-1:0] hold_reg;
    logic [DW*RATIO-1:0] hold_next;
    logic [IDX_W-1:0]    idx_reg;
    logic [IDX_W-1:0]    idx_next;
    logic                valid_reg;
    logic                valid_next;

    logic at_last;
    logic in_fire;
    logic out_fire;

    assign at_last  = (idx_reg == LAST_IDX);
    assign in_fire  = in_valid && in_ready;
    assign out_fire = valid_reg && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg  <= '0;
            idx_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            hold_reg  <= hold_next;
            idx_reg   <= idx_next;
            valid_reg <= valid_next;
        end
    end

    // A load always wins, including on the final beat of the previous word.
    always_comb begin
        hold_next  = hold_reg;
        idx_next   = idx_reg;
        valid_next = valid_reg;
        if (in_fire) begin
            hold_next  = in_data;
            idx_next   = '0;
            valid_next = 1'b1;
        end else if (out_fire) begin
            if (at_last) begin
                idx_next   = '0;
                valid_next = 1'b0;
            end else begin
                hold_next = hold_reg >> DW;
                idx_next  = idx_reg + IDX_W'(1);
            end
        end
    end

    always_comb begin
        out_valid = valid_reg;
        out_data  = hold_reg[DW-1:0];
        out_last  = valid_reg && at_last;
        in_ready  = !valid_reg || (out_ready && at_last);
    end

endmodule

// File: tb/tb_armleo_stream_serializer.sv
// Bench for armleo_stream_serializer: directed vector table on DW=8/RATIO=4, hand-written reset
// sequence, and randomized stall sweeps on DW=1/RATIO=2 and DW=16/RATIO=3 against a beat queue model.
module tb_armleo_stream_serializer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Main instance, DW=8 RATIO=4
    logic        m_in_valid = 1'b0;
    logic [31:0] m_in_data = '0;
    logic        m_in_ready;
    logic        m_out_valid;
    logic [7:0]  m_out_data;
    logic        m_out_last;
    logic        m_out_ready = 1'b0;

    armleo_stream_serializer #(.DW(8), .RATIO(4)) u_main (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (m_in_valid),
        .in_data   (m_in_data),
        .in_ready  (m_in_ready),
        .out_valid (m_out_valid),
        .out_data  (m_out_data),
        .out_last  (m_out_last),
        .out_ready (m_out_ready)
    );

    // Sweep instance A, DW=1 RATIO=2
    logic       a_in_valid = 1'b0;
    logic [1:0] a_in_data = '0;
    logic       a_in_ready;
    logic       a_out_valid;
    logic [0:0] a_out_data;
    logic       a_out_last;
    logic       a_out_ready = 1'b0;

    armleo_stream_serializer #(.DW(1), .RATIO(2)) u_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_data   (a_in_data),
        .in_ready  (a_in_ready),
        .out_valid (a_out_valid),
        .out_data  (a_out_data),
        .out_last  (a_out_last),
        .out_ready (a_out_ready)
    );

    // Sweep instance B, DW=16 RATIO=3
    logic        b_in_valid = 1'b0;
    logic [47:0] b_in_data = '0;
    logic        b_in_ready;
    logic        b_out_valid;
    logic [15:0] b_out_data;
    logic        b_out_last;
    logic        b_out_ready = 1'b0;

    armleo_stream_serializer #(.DW(16), .RATIO(3)) u_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_data   (b_in_data),
        .in_ready  (b_in_ready),
        .out_valid (b_out_valid),
        .out_data  (b_out_data),
        .out_last  (b_out_last),
        .out_ready (b_out_ready)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        ov;
        logic [7:0]  od;
        logic        ol;
        logic        ir;
        logic        chkd;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic iv, input logic [31:0] d, input logic ordy, input logic ov,
                       input logic [7:0] od, input logic ol, input logic ir, input logic chkd);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.ov = ov;
        v.od = od; v.ol = ol; v.ir = ir; v.chkd = chkd;
        vecs.push_back(v);
    endtask

    typedef struct {
        logic [15:0] d;
        logic        l;
    } beat_t;

    beat_t a_q[$];
    beat_t b_q[$];
    int    a_words = 0, a_lasts = 0;
    int    b_words = 0, b_lasts = 0;

    initial begin
        beat_t e;
        logic        a_stall, b_stall;
        logic [15:0] a_pd, b_pd;
        logic        a_pl, b_pl;

        // Single word
        add(1, 32'h44332211, 1, 0, 8'h00, 0, 1, 1);
        add(0, 32'h0, 1, 1, 8'h11, 0, 0, 1);
        add(0, 32'h0, 1, 1, 8'h22, 0, 0, 1);
        add(0, 32'h0, 1, 1, 8'h33, 0, 0, 1);
        add(0, 32'h0, 1, 1, 8'h44, 1, 1, 1);
        add(0, 32'h0, 1, 0, 8'h00, 0, 1, 0);
        // Back-to-back
        add(1, 32'h44332211, 1, 0, 8'h00, 0, 1, 0);
        add(1, 32'h88776655, 1, 1, 8'h11, 0, 0, 1);
        add(1, 32'h88776655, 1, 1, 8'h22, 0, 0, 1);
        add(1, 32'h88776655, 1, 1, 8'h33, 0, 0, 1);
        add(1, 32'h88776655, 1, 1, 8'h44, 1, 1, 1);
        add(0, 32'h0, 1, 1, 8'h55, 0, 0, 1);
        add(0, 32'h0, 1, 1, 8'h66, 0, 0, 1);
        add(0, 32'h0, 1, 1, 8'h77, 0, 0, 1);
        add(0, 32'h0, 1, 1, 8'h88, 1, 1, 1);
        add(0, 32'h0, 1, 0, 8'h00, 0, 1, 0);
        // Backpressure mid-word and on the last beat
        add(1, 32'h44332211, 1, 0, 8'h00, 0, 1, 0);
        add(0, 32'h0, 1, 1, 8'h11, 0, 0, 1);
        add(0, 32'h0, 0, 1, 8'h22, 0, 0, 1);
        add(0, 32'h0, 0, 1, 8'h22, 0, 0, 1);
        add(0, 32'h0, 0, 1, 8'h22, 0, 0, 1);
        add(0, 32'h0, 1, 1, 8'h22, 0, 0, 1);
        add(0, 32'h0, 1, 1, 8'h33, 0, 0, 1);
        add(0, 32'h0, 0, 1, 8'h44, 1, 0, 1);
        add(0, 32'h0, 1, 1, 8'h44, 1, 1, 1);
        add(0, 32'h0, 1, 0, 8'h00, 0, 1, 0);
        // Upstream waits; in_data changes while not accepted
        add(1, 32'h44332211, 1, 0, 8'h00, 0, 1, 0);
        add(0, 32'h0, 1, 1, 8'h11, 0, 0, 1);
        add(1, 32'h12345678, 1, 1, 8'h22, 0, 0, 1);
        add(1, 32'hDEADBEEF, 1, 1, 8'h33, 0, 0, 1);
        add(1, 32'hDEADBEEF, 1, 1, 8'h44, 1, 1, 1);
        add(0, 32'h0, 1, 1, 8'hEF, 0, 0, 1);
        add(0, 32'h0, 1, 1, 8'hBE, 0, 0, 1);
        add(0, 32'h0, 1, 1, 8'hAD, 0, 0, 1);
        add(0, 32'h0, 1, 1, 8'hDE, 1, 1, 1);
        add(0, 32'h0, 1, 0, 8'h00, 0, 1, 0);
        // Load while idle with out_ready low, then drain
        add(1, 32'hCAFEF00D, 0, 0, 8'h00, 0, 1, 0);
        add(0, 32'h0, 0, 1, 8'h0D, 0, 0, 1);
        add(0, 32'h0, 1, 1, 8'h0D, 0, 0, 1);
        add(0, 32'h0, 1, 1, 8'hF0, 0, 0, 1);
        add(0, 32'h0, 1, 1, 8'hFE, 0, 0, 1);
        add(0, 32'h0, 1, 1, 8'hCA, 1, 1, 1);
        add(0, 32'h0, 1, 0, 8'h00, 0, 1, 0);

        // Reset state
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_out_valid", 64'(m_out_valid), 64'(0));
        chk("reset_out_data", 64'(m_out_data), 64'(0));
        chk("reset_out_last", 64'(m_out_last), 64'(0));
        chk("reset_in_ready", 64'(m_in_ready), 64'(1));

        foreach (vecs[i]) begin
            @(negedge clk);
            m_in_valid  = vecs[i].iv;
            m_in_data   = vecs[i].d;
            m_out_ready = vecs[i].ordy;
            #1;
            $display("row %0d: iv=%0b d=%h ordy=%0b -> ov=%0b od=%h ol=%0b ir=%0b", i,
                     m_in_valid, m_in_data, m_out_ready, m_out_valid, m_out_data, m_out_last, m_in_ready);
            chk($sformatf("row%0d_out_valid", i), 64'(m_out_valid), 64'(vecs[i].ov));
            chk($sformatf("row%0d_out_last", i), 64'(m_out_last), 64'(vecs[i].ol));
            chk($sformatf("row%0d_in_ready", i), 64'(m_in_ready), 64'(vecs[i].ir));
            if (vecs[i].chkd)
                chk($sformatf("row%0d_out_data", i), 64'(m_out_data), 64'(vecs[i].od));
        end

        // Reset mid-word: asynchronous, takes effect with no clock edge
        @(negedge clk);
        m_in_valid = 1'b1; m_in_data = 32'h44332211; m_out_ready = 1'b1;
        @(negedge clk);
        m_in_valid = 1'b0;
        #1 chk("rst_seq_beat0", 64'(m_out_data), 64'h11);
        @(negedge clk);
        #1 chk("rst_seq_beat1", 64'(m_out_data), 64'h22);
        @(negedge clk);
        #1 chk("rst_seq_beat2_valid", 64'(m_out_valid), 64'(1));
        #1 rst_n = 1'b0;
        #1;
        $display("async reset: ov=%0b ol=%0b od=%h", m_out_valid, m_out_last, m_out_data);
        chk("rst_async_out_valid", 64'(m_out_valid), 64'(0));
        chk("rst_async_out_last", 64'(m_out_last), 64'(0));
        chk("rst_async_out_data", 64'(m_out_data), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        m_in_valid = 1'b1; m_in_data = 32'h0A0B0C0D;
        #1 chk("rst_after_in_ready", 64'(m_in_ready), 64'(1));
        @(negedge clk);
        m_in_valid = 1'b0;
        #1;
        chk("rst_after_out_valid", 64'(m_out_valid), 64'(1));
        chk("rst_after_out_data", 64'(m_out_data), 64'h0D);
        chk("rst_after_out_last", 64'(m_out_last), 64'(0));
        @(negedge clk);
        #1 chk("rst_after_beat1", 64'(m_out_data), 64'h0C);

        // Randomized sweep on the two other configurations
        a_stall = 1'b0; b_stall = 1'b0;
        a_pd = '0; b_pd = '0; a_pl = 1'b0; b_pl = 1'b0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            if (cyc < 600) begin
                a_in_valid = 1'($urandom_range(0, 1));
                b_in_valid = 1'($urandom_range(0, 1));
                a_out_ready = ($urandom_range(0, 3) != 0);
                b_out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                a_in_valid = 1'b0; b_in_valid = 1'b0;
                a_out_ready = 1'b1; b_out_ready = 1'b1;
            end
            a_in_data = 2'($urandom);
            b_in_data = {16'($urandom), 32'($urandom)};
            #1;
            if (a_stall) begin
                chk("a_stall_valid", 64'(a_out_valid), 64'(1));
                chk("a_stall_data", 64'(a_out_data), 64'(a_pd));
                chk("a_stall_last", 64'(a_out_last), 64'(a_pl));
            end
            if (b_stall) begin
                chk("b_stall_valid", 64'(b_out_valid), 64'(1));
                chk("b_stall_data", 64'(b_out_data), 64'(b_pd));
                chk("b_stall_last", 64'(b_out_last), 64'(b_pl));
            end
            if (a_out_valid && a_out_ready) begin
                if (a_q.size() == 0) chk("a_unexpected_beat", 64'(1), 64'(0));
                else begin
                    e = a_q.pop_front();
                    chk("a_beat_data", 64'(a_out_data), 64'(e.d));
                    chk("a_beat_last", 64'(a_out_last), 64'(e.l));
                end
                if (a_out_last) a_lasts++;
            end
            if (b_out_valid && b_out_ready) begin
                if (b_q.size() == 0) chk("b_unexpected_beat", 64'(1), 64'(0));
                else begin
                    e = b_q.pop_front();
                    chk("b_beat_data", 64'(b_out_data), 64'(e.d));
                    chk("b_beat_last", 64'(b_out_last), 64'(e.l));
                end
                if (b_out_last) b_lasts++;
            end
            if (a_in_valid && a_in_ready) begin
                for (int k = 0; k < 2; k++) begin
                    e.d = 16'((a_in_data >> k) & 2'b01);
                    e.l = (k == 1);
                    a_q.push_back(e);
                end
                a_words++;
                $display("A word %0d accepted: %h", a_words, a_in_data);
            end
            if (b_in_valid && b_in_ready) begin
                for (int k = 0; k < 3; k++) begin
                    e.d = 16'(b_in_data >> (16 * k));
                    e.l = (k == 2);
                    b_q.push_back(e);
                end
                b_words++;
                $display("B word %0d accepted: %h", b_words, b_in_data);
            end
            a_stall = a_out_valid && !a_out_ready;
            b_stall = b_out_valid && !b_out_ready;
            a_pd = 16'(a_out_data); a_pl = a_out_last;
            b_pd = b_out_data;      b_pl = b_out_last;
        end
        chk("a_queue_drained", 64'(a_q.size()), 64'(0));
        chk("b_queue_drained", 64'(b_q.size()), 64'(0));
        chk("a_last_per_word", 64'(a_lasts), 64'(a_words));
        chk("b_last_per_word", 64'(b_lasts), 64'(b_words));
        chk("a_words_nonzero", 64'(a_words > 10), 64'(1));
        chk("b_words_nonzero", 64'(b_words > 10), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
